// File: rtl/bert_pkg.sv
// Shared state, PN selection codes and polynomial constants for the BERT PN checker.
package bert_pkg;

    localparam int PRED_W = 23;

    typedef enum logic [1:0] {LOAD, SYNC, LOCKED} state_t;

    typedef enum logic [1:0] {
        PN9  = 2'b00,
        PN11 = 2'b01,
        PN15 = 2'b10,
        PN23 = 2'b11
    } pn_sel_t;

    localparam int ORDER_PN9  = 9;
    localparam int ORDER_PN11 = 11;
    localparam int ORDER_PN15 = 15;
    localparam int ORDER_PN23 = 23;

    localparam int TAP_PN9  = 5;
    localparam int TAP_PN11 = 9;
    localparam int TAP_PN15 = 14;
    localparam int TAP_PN23 = 18;

    function automatic logic [4:0] pn_order(input logic [1:0] sel);
        case (pn_sel_t'(sel))
            PN9:     return 5'(ORDER_PN9);
            PN11:    return 5'(ORDER_PN11);
            PN15:    return 5'(ORDER_PN15);
            default: return 5'(ORDER_PN23);
        endcase
    endfunction

endpackage

// File: rtl/bert_pn_pred.sv
// PN predictor: 23-bit history register, newest bit at [0], with per-polynomial tap selection.
module bert_pn_pred
    import bert_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_shift_en,
    input  logic       i_serial,
    input  logic [1:0] i_pn_sel,
    output logic       o_pred
);

    logic [PRED_W-1:0] r_sr;
    logic              w_pred;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr <= '0;
        end else if (i_shift_en) begin
            r_sr <= {r_sr[PRED_W-2:0], i_serial};
        end
    end

    // Bit at index n-1 is b[t-n]; the next bit of x^n+x^k+1 is b[t-n] ^ b[t-k].
    always_comb begin
        w_pred = 1'b0;
        case (pn_sel_t'(i_pn_sel))
            PN9:     w_pred = r_sr[ORDER_PN9-1]  ^ r_sr[TAP_PN9-1];
            PN11:    w_pred = r_sr[ORDER_PN11-1] ^ r_sr[TAP_PN11-1];
            PN15:    w_pred = r_sr[ORDER_PN15-1] ^ r_sr[TAP_PN15-1];
            default: w_pred = r_sr[ORDER_PN23-1] ^ r_sr[TAP_PN23-1];
        endcase
    end

    assign o_pred = w_pred;

endmodule

// File: rtl/bert_pn_checker.sv
// Self-synchronising PN checker with flywheel lock and windowed bit/error counting.
// Optional BERT_INVERT_EN adds an 'invert' input that flips din before all checking.
module bert_pn_checker
    import bert_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_BITS   = 64,
    parameter int LOSS_BLK    = 128,
    parameter int LOSS_THRESH = 16
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             enable,
    input  logic [1:0]       pn_sel,
    input  logic             resync,
`ifdef BERT_INVERT_EN
    input  logic             invert,
`endif
    input  logic [CNT_W-1:0] window_len,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             window_done
);

    localparam int SYNC_W = $clog2(SYNC_BITS + 1);
    localparam int BLK_W  = $clog2(LOSS_BLK + 1);
    localparam int BERR_W = $clog2(LOSS_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state, w_next_state;
    logic [4:0]        r_load_cnt;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic [BLK_W-1:0]  r_blk_cnt;
    logic [BERR_W-1:0] r_blk_errs;
    logic [CNT_W-1:0]  r_acc_bits, r_acc_errs, r_bit_count, r_err_count;
    logic              r_window_done;
    logic [1:0]        r_pn_sel_q;

    logic              w_din, w_pred, w_err, w_restart, w_load_done, w_sync_done;
    logic              w_loss, w_blk_wrap, w_win_end;
    logic [4:0]        w_order;
    logic [CNT_W-1:0]  w_acc_bits_inc, w_acc_errs_inc;

`ifdef BERT_INVERT_EN
    assign w_din = din ^ invert;
`else
    assign w_din = din;
`endif

    // Once locked the predictor free-runs on its own output so line errors do not propagate.
    bert_pn_pred u_pred (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_shift_en (enable),
        .i_serial   ((r_state == LOCKED) ? w_pred : w_din),
        .i_pn_sel   (pn_sel),
        .o_pred     (w_pred)
    );

    always_comb begin
        w_order        = pn_order(pn_sel);
        w_err          = w_din ^ w_pred;
        w_restart      = resync || (pn_sel != r_pn_sel_q);
        w_load_done    = (r_load_cnt + 5'd1) == w_order;
        w_sync_done    = !w_err && (r_sync_cnt == SYNC_W'(SYNC_BITS - 1));
        w_loss         = w_err && (r_blk_errs == BERR_W'(LOSS_THRESH - 1));
        w_blk_wrap     = r_blk_cnt == BLK_W'(LOSS_BLK - 1);
        w_acc_bits_inc = (r_acc_bits == CNT_MAX) ? r_acc_bits : r_acc_bits + CNT_W'(1);
        w_acc_errs_inc = (w_err && (r_acc_errs != CNT_MAX)) ? r_acc_errs + CNT_W'(1) : r_acc_errs;
        w_win_end      = (window_len != '0) && (w_acc_bits_inc == window_len);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_restart) begin
            w_next_state = LOAD;
        end else if (enable) begin
            case (r_state)
                LOAD:    if (w_load_done) w_next_state = SYNC;
                SYNC:    if (w_err) w_next_state = LOAD;
                         else if (w_sync_done) w_next_state = LOCKED;
                LOCKED:  if (w_loss) w_next_state = LOAD;
                default: w_next_state = LOAD;
            endcase
        end
    end

    // Restart and loss of lock discard the partial window; latched results survive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pn_sel_q    <= pn_sel;
            r_load_cnt    <= '0;
            r_sync_cnt    <= '0;
            r_blk_cnt     <= '0;
            r_blk_errs    <= '0;
            r_acc_bits    <= '0;
            r_acc_errs    <= '0;
            r_bit_count   <= '0;
            r_err_count   <= '0;
            r_window_done <= 1'b0;
        end else begin
            r_pn_sel_q    <= pn_sel;
            r_window_done <= 1'b0;
            if (w_restart || (enable && (r_state == LOCKED) && w_loss)) begin
                r_load_cnt <= '0;
                r_sync_cnt <= '0;
                r_blk_cnt  <= '0;
                r_blk_errs <= '0;
                r_acc_bits <= '0;
                r_acc_errs <= '0;
            end else if (enable) begin
                case (r_state)
                    LOAD: r_load_cnt <= w_load_done ? '0 : r_load_cnt + 5'd1;
                    SYNC: r_sync_cnt <= (w_err || w_sync_done) ? '0 : r_sync_cnt + SYNC_W'(1);
                    LOCKED: begin
                        r_blk_cnt  <= w_blk_wrap ? '0 : r_blk_cnt + BLK_W'(1);
                        r_blk_errs <= w_blk_wrap ? '0 : r_blk_errs + BERR_W'(w_err);
                        if (w_win_end) begin
                            r_bit_count   <= window_len;
                            r_err_count   <= w_acc_errs_inc;
                            r_window_done <= 1'b1;
                            r_acc_bits    <= '0;
                            r_acc_errs    <= '0;
                        end else begin
                            r_acc_bits <= w_acc_bits_inc;
                            r_acc_errs <= w_acc_errs_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign locked      = (r_state == LOCKED);
    assign bit_count   = r_bit_count;
    assign err_count   = r_err_count;
    assign window_done = r_window_done;

endmodule

// File: tb/tb_bert_pn_checker.sv
// Bench for bert_pn_checker: a bit-history reference model is compared every cycle,
// with literal checkpoints on lock timing and window results.
`timescale 1ns/1ps
module tb_bert_pn_checker;

    localparam int CNT_W       = 32;
    localparam int SYNC_BITS   = 64;
    localparam int LOSS_BLK    = 128;
    localparam int LOSS_THRESH = 16;

    logic             clk = 1'b0;
    logic             reset_n, din, enable, resync, invert;
    logic [1:0]       pn_sel;
    logic [CNT_W-1:0] window_len;
    logic             locked, window_done;
    logic [CNT_W-1:0] bit_count, err_count;

    bert_pn_checker #(
        .CNT_W(CNT_W), .SYNC_BITS(SYNC_BITS), .LOSS_BLK(LOSS_BLK), .LOSS_THRESH(LOSS_THRESH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .enable      (enable),
        .pn_sel      (pn_sel),
        .resync      (resync),
`ifdef BERT_INVERT_EN
        .invert      (invert),
`endif
        .window_len  (window_len),
        .locked      (locked),
        .bit_count   (bit_count),
        .err_count   (err_count),
        .window_done (window_done)
    );

    always #5 clk = ~clk;

    int  checkCount = 0;
    int  errorCount = 0;
    int  doneSeen   = 0;
    bit  checkEn    = 1'b0;

    bit          mLocked, mDone;
    int          mLoadCnt, mRun, mBlkBits, mBlkErrs;
    longint      mAccBits, mAccErrs;
    logic [31:0] mBitCount, mErrCount;
    logic [1:0]  mPrevSel;
    bit          predHist[$];
    bit          genHist[$];

    function automatic int orderOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 9;
            2'b01:   return 11;
            2'b10:   return 15;
            default: return 23;
        endcase
    endfunction

    function automatic int tapOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5;
            2'b01:   return 9;
            2'b10:   return 14;
            default: return 18;
        endcase
    endfunction

    function automatic void seedGen();
        genHist.delete();
        repeat (23) genHist.push_back(1'b1);
    endfunction

    function automatic bit nextPn(input logic [1:0] sel);
        bit b;
        b = genHist[orderOf(sel)-1] ^ genHist[tapOf(sel)-1];
        genHist.push_front(b);
        if (genHist.size() > 23) void'(genHist.pop_back());
        return b;
    endfunction

    function automatic void pushHist(input bit b);
        predHist.push_front(b);
        if (predHist.size() > 23) void'(predHist.pop_back());
    endfunction

    function automatic void restartAcq();
        mLocked  = 1'b0;
        mLoadCnt = 0;
        mRun     = 0;
        mAccBits = 0;
        mAccErrs = 0;
        mBlkBits = 0;
        mBlkErrs = 0;
    endfunction

    // Reference behaviour for one clock edge, given the inputs the DUT sampled on it.
    task automatic modelStep(input logic b, input logic en, input logic rs,
                             input logic [1:0] sel, input logic [31:0] wl);
        bit d, p, e;
        mDone = 1'b0;
        if (!reset_n) begin
            restartAcq();
            mBitCount = 0;
            mErrCount = 0;
            mPrevSel  = sel;
            predHist.delete();
            return;
        end
        if (rs || (sel != mPrevSel)) begin
            mPrevSel = sel;
            restartAcq();
            return;
        end
        if (!en) return;
        d = b ^ invert;
        if (!mLocked) begin
            if (mLoadCnt < orderOf(sel)) begin
                pushHist(d);
                mLoadCnt++;
            end else begin
                p = predHist[orderOf(sel)-1] ^ predHist[tapOf(sel)-1];
                pushHist(d);
                if (p == d) begin
                    mRun++;
                    if (mRun == SYNC_BITS) mLocked = 1'b1;
                end else begin
                    mLoadCnt = 0;
                    mRun     = 0;
                end
            end
        end else begin
            p = predHist[orderOf(sel)-1] ^ predHist[tapOf(sel)-1];
            pushHist(p);
            e = d ^ p;
            mAccBits++;
            mAccErrs += e;
            mBlkBits++;
            mBlkErrs += e;
            if (mBlkErrs == LOSS_THRESH) begin
                restartAcq();
            end else begin
                if (mBlkBits == LOSS_BLK) begin
                    mBlkBits = 0;
                    mBlkErrs = 0;
                end
                if ((wl != 0) && (mAccBits == longint'(wl))) begin
                    mBitCount = wl;
                    mErrCount = (mAccErrs > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mAccErrs[31:0];
                    mDone     = 1'b1;
                    mAccBits  = 0;
                    mAccErrs  = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic en, input logic rs);
        din    = b;
        enable = en;
        resync = rs;
        @(posedge clk);
        modelStep(b, en, rs, pn_sel, window_len);
        @(negedge clk);
        #1;
    endtask

    task automatic sendBits(input int n, input int gap, input int errEvery, input bit inv);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = nextPn(pn_sel) ^ inv;
            if ((errEvery != 0) && (((i + 1) % errEvery) == 0)) b = ~b;
            applyStimulus(b, 1'b1, 1'b0);
            for (int j = 1; j < gap; j++) applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("locked", locked, mLocked);
            checkOutput("window_done", window_done, mDone);
            checkOutput("bit_count", bit_count, mBitCount);
            checkOutput("err_count", err_count, mErrCount);
            if (window_done) doneSeen++;
        end
    end

    initial begin
        int doneBase;
        reset_n = 1'b0; din = 1'b0; enable = 1'b0; resync = 1'b0; invert = 1'b0;
        pn_sel = 2'b00; window_len = 1000;
        seedGen();
        @(negedge clk);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_bit_count", bit_count, 0);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_window_done", window_done, 0);
        reset_n = 1'b1;

        $display("[TB] PN9, enable every 4th cycle, window 1000");
        sendBits(72, 4, 0, 1'b0);
        checkOutput("pn9_not_locked_72", locked, 0);
        sendBits(1, 4, 0, 1'b0);
        checkOutput("pn9_locked_73", locked, 1);
        doneBase = doneSeen;
        sendBits(2000, 4, 0, 1'b0);
        checkOutput("pn9_windows", doneSeen - doneBase, 2);
        checkOutput("pn9_bit_count", bit_count, 1000);
        checkOutput("pn9_err_count", err_count, 0);

        $display("[TB] PN15, one error per 100 bits, window 10000");
        window_len = 10000;
        pn_sel = 2'b10;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pn15_unlock_on_sel", locked, 0);
        sendBits(78, 1, 0, 1'b0);
        checkOutput("pn15_not_locked_78", locked, 0);
        sendBits(1, 1, 0, 1'b0);
        checkOutput("pn15_locked_79", locked, 1);
        sendBits(10000, 1, 100, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pn15_bit_count", bit_count, 10000);
        checkOutput("pn15_err_count", err_count, 100);
        checkOutput("pn15_still_locked", locked, 1);

        $display("[TB] PN23, inverted stream forces loss, then reacquire");
        window_len = 500;
        pn_sel = 2'b11;
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendBits(86, 1, 0, 1'b0);
        checkOutput("pn23_not_locked_86", locked, 0);
        sendBits(1, 1, 0, 1'b0);
        checkOutput("pn23_locked_87", locked, 1);
        sendBits(200, 1, 0, 1'b0);
        sendBits(15, 1, 0, 1'b1);
        checkOutput("pn23_locked_15_errs", locked, 1);
        sendBits(1, 1, 0, 1'b1);
        checkOutput("pn23_loss_16_errs", locked, 0);
        sendBits(86, 1, 0, 1'b0);
        checkOutput("pn23_relock_not_86", locked, 0);
        sendBits(1, 1, 0, 1'b0);
        checkOutput("pn23_relock_87", locked, 1);

        $display("[TB] resync coincident with window end");
        doneBase = doneSeen;
        sendBits(499, 1, 0, 1'b0);
        applyStimulus(nextPn(pn_sel), 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("resync_no_done", doneSeen - doneBase, 0);
        checkOutput("resync_bit_count_held", bit_count, 10000);
        checkOutput("resync_err_count_held", err_count, 100);
        checkOutput("resync_unlocked", locked, 0);
        sendBits(86, 1, 0, 1'b0);
        checkOutput("resync_not_86", locked, 0);
        sendBits(1, 1, 0, 1'b0);
        checkOutput("resync_relock_87", locked, 1);

        $display("[TB] PN11 free-running, window_len 0");
        reset_n = 1'b0;
        window_len = 0;
        pn_sel = 2'b01;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        sendBits(75, 1, 0, 1'b0);
        checkOutput("pn11_locked_75", locked, 1);
        doneBase = doneSeen;
        sendBits(5000, 1, 0, 1'b0);
        checkOutput("pn11_no_windows", doneSeen - doneBase, 0);
        checkOutput("pn11_bit_count", bit_count, 0);
        checkOutput("pn11_err_count", err_count, 0);
        checkOutput("pn11_still_locked", locked, 1);

`ifdef BERT_INVERT_EN
        $display("[TB] inverted PN9 link with invert input");
        reset_n = 1'b0;
        window_len = 1000;
        pn_sel = 2'b00;
        invert = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        sendBits(73, 1, 0, 1'b1);
        checkOutput("inv_locked", locked, 1);
        sendBits(1000, 1, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("inv_bit_count", bit_count, 1000);
        checkOutput("inv_err_count", err_count, 0);
        invert = 1'b0;
        sendBits(600, 1, 0, 1'b1);
        checkOutput("inv_off_never_locks", locked, 0);
`endif

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
